// File: rtl/alarm_response_unit.sv
// Caregiver-side alarm responder: synchronises the bed-alarm level and the acknowledge button,
// drives a pulsed buzzer that escalates to continuous, and snoozes on a debounced acknowledge.
module alarm_response_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_ON         = 8,
    parameter int BEEP_OFF        = 8,
    parameter int ESCALATE_CYCLES = 64,
    parameter int SNOOZE_CYCLES   = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alarm_in,
    input  logic       ack_btn,
    output logic       buzzer,
    output logic       led,
    output logic       escalate,
    output logic       ack_pulse,
    output logic [1:0] state_o
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int BPW = $clog2(BEEP_ON + BEEP_OFF) + 1;
    localparam int ESW = $clog2(ESCALATE_CYCLES) + 1;
    localparam int SNW = $clog2(SNOOZE_CYCLES) + 1;

    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES);
    localparam logic [BPW-1:0] BEEP_ON_C = BPW'(BEEP_ON);
    localparam logic [BPW-1:0] BEEP_LAST = BPW'(BEEP_ON + BEEP_OFF - 1);
    localparam logic [ESW-1:0] ESC_LAST  = ESW'(ESCALATE_CYCLES - 1);
    localparam logic [SNW-1:0] SNZ_LAST  = SNW'(SNOOZE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RINGING   = 2'd1,
        ESCALATED = 2'd2,
        SNOOZE    = 2'd3
    } state_t;

    logic           alarm_meta_r, alarm_sync_r;
    logic           ack_meta_r, ack_sync_r;
    logic [DBW-1:0] db_cnt_r, db_cnt_nxt_s;
    logic           ack_db_r, ack_db_d_r, ack_evt_s;
    state_t         state_r, state_nxt_s;
    logic [BPW-1:0] beep_cnt_r, beep_nxt_s;
    logic [ESW-1:0] esc_cnt_r, esc_nxt_s;
    logic [SNW-1:0] snz_cnt_r, snz_nxt_s;
    logic           buzzer_r, led_r, escalate_r, ack_pulse_r;
    logic           buzzer_nxt_s, led_nxt_s, escalate_nxt_s, ack_pulse_nxt_s;

    // Two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_meta_r <= 1'b0;
            alarm_sync_r <= 1'b0;
            ack_meta_r   <= 1'b0;
            ack_sync_r   <= 1'b0;
        end else begin
            alarm_meta_r <= alarm_in;
            alarm_sync_r <= alarm_meta_r;
            ack_meta_r   <= ack_btn;
            ack_sync_r   <= ack_meta_r;
        end
    end

    // Saturating debounce count of consecutive synced-high button samples
    always_comb begin
        db_cnt_nxt_s = {DBW{1'b0}};
        if (ack_sync_r) begin
            if (db_cnt_r == DB_MAX) begin
                db_cnt_nxt_s = DB_MAX;
            end else begin
                db_cnt_nxt_s = db_cnt_r + DBW'(1);
            end
        end else begin
            db_cnt_nxt_s = {DBW{1'b0}};
        end
    end

    // Debounced level and its delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r   <= {DBW{1'b0}};
            ack_db_r   <= 1'b0;
            ack_db_d_r <= 1'b0;
        end else begin
            db_cnt_r   <= db_cnt_nxt_s;
            ack_db_r   <= ack_sync_r & (db_cnt_nxt_s == DB_MAX);
            ack_db_d_r <= ack_db_r;
        end
    end

    assign ack_evt_s = ack_db_r & ~ack_db_d_r;

    // Next state, counters and the registered-output values they imply
    always_comb begin
        state_nxt_s     = state_r;
        beep_nxt_s      = beep_cnt_r;
        esc_nxt_s       = esc_cnt_r;
        snz_nxt_s       = snz_cnt_r;
        ack_pulse_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (alarm_sync_r) begin
                    state_nxt_s = RINGING;
                    beep_nxt_s  = {BPW{1'b0}};
                    esc_nxt_s   = {ESW{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RINGING: begin
                if (ack_evt_s) begin
                    state_nxt_s     = SNOOZE;
                    snz_nxt_s       = {SNW{1'b0}};
                    ack_pulse_nxt_s = 1'b1;
                end else if (esc_cnt_r == ESC_LAST) begin
                    state_nxt_s = ESCALATED;
                end else if (!alarm_sync_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    beep_nxt_s = (beep_cnt_r == BEEP_LAST) ? {BPW{1'b0}} : beep_cnt_r + BPW'(1);
                    esc_nxt_s  = esc_cnt_r + ESW'(1);
                end
            end
            ESCALATED: begin
                // Latched: only an acknowledge leaves this state
                if (ack_evt_s) begin
                    state_nxt_s     = SNOOZE;
                    snz_nxt_s       = {SNW{1'b0}};
                    ack_pulse_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ESCALATED;
                end
            end
            SNOOZE: begin
                if (!alarm_sync_r) begin
                    state_nxt_s = IDLE;
                end else if (snz_cnt_r == SNZ_LAST) begin
                    state_nxt_s = RINGING;
                    beep_nxt_s  = {BPW{1'b0}};
                    esc_nxt_s   = {ESW{1'b0}};
                end else begin
                    snz_nxt_s = snz_cnt_r + SNW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        led_nxt_s      = (state_nxt_s != IDLE);
        escalate_nxt_s = (state_nxt_s == ESCALATED);
        case (state_nxt_s)
            RINGING:   buzzer_nxt_s = (beep_nxt_s < BEEP_ON_C);
            ESCALATED: buzzer_nxt_s = 1'b1;
            default:   buzzer_nxt_s = 1'b0;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            beep_cnt_r  <= {BPW{1'b0}};
            esc_cnt_r   <= {ESW{1'b0}};
            snz_cnt_r   <= {SNW{1'b0}};
            buzzer_r    <= 1'b0;
            led_r       <= 1'b0;
            escalate_r  <= 1'b0;
            ack_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            beep_cnt_r  <= beep_nxt_s;
            esc_cnt_r   <= esc_nxt_s;
            snz_cnt_r   <= snz_nxt_s;
            buzzer_r    <= buzzer_nxt_s;
            led_r       <= led_nxt_s;
            escalate_r  <= escalate_nxt_s;
            ack_pulse_r <= ack_pulse_nxt_s;
        end
    end

    assign buzzer    = buzzer_r;
    assign led       = led_r;
    assign escalate  = escalate_r;
    assign ack_pulse = ack_pulse_r;
    assign state_o   = state_r;

endmodule

// File: tb/tb_alarm_response_unit.sv
// Directed, table-driven bench for alarm_response_unit with default parameters.
module tb_alarm_response_unit;

    logic       clk;
    logic       rst_n;
    logic       alarm_in;
    logic       ack_btn;
    logic       buzzer;
    logic       led;
    logic       escalate;
    logic       ack_pulse;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;
    int rc;

    typedef struct {
        logic       alarm;
        logic       ack;
        logic [1:0] st;
        logic       bz;
        logic       ld;
        logic       es;
        logic       ap;
    } vec_t;

    vec_t tbl [80];

    alarm_response_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alarm_in  (alarm_in),
        .ack_btn   (ack_btn),
        .buzzer    (buzzer),
        .led       (led),
        .escalate  (escalate),
        .ack_pulse (ack_pulse),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected buzzer level in RINGING cycle c: 8 high then 8 low
    function automatic logic beep_model(input int c);
        return ((c % 16) < 8);
    endfunction

    task automatic chk(input string name, input logic [1:0] e_st, input logic e_bz,
                       input logic e_ld, input logic e_es, input logic e_ap);
        total++;
        if ({state_o, buzzer, led, escalate, ack_pulse} !== {e_st, e_bz, e_ld, e_es, e_ap}) begin
            bad++;
            $display("FAIL %s @%0t: got state=%0d buzzer=%b led=%b escalate=%b ack_pulse=%b, want state=%0d buzzer=%b led=%b escalate=%b ack_pulse=%b",
                     name, $time, state_o, buzzer, led, escalate, ack_pulse, e_st, e_bz, e_ld, e_es, e_ap);
        end
    endtask

    // Drive inputs at a falling edge and advance to the next falling edge
    task automatic step(input logic a, input logic b);
        alarm_in = a;
        ack_btn  = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        alarm_in = 1'b0;
        ack_btn  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_values", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic glitch [18];

        // Table: reset -> ringing pattern -> escalation -> alarm drop while escalated
        for (int i = 0; i < 80; i++) begin
            tbl[i].alarm = (i < 70);
            tbl[i].ack   = 1'b0;
            tbl[i].ap    = 1'b0;
            if (i < 2) begin
                tbl[i].st = 2'd0; tbl[i].bz = 1'b0; tbl[i].ld = 1'b0; tbl[i].es = 1'b0;
            end else if (i < 66) begin
                tbl[i].st = 2'd1; tbl[i].bz = beep_model(i - 2); tbl[i].ld = 1'b1; tbl[i].es = 1'b0;
            end else begin
                tbl[i].st = 2'd2; tbl[i].bz = 1'b1; tbl[i].ld = 1'b1; tbl[i].es = 1'b1;
            end
        end

        glitch = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n    = 1'b1;
        alarm_in = 1'b0;
        ack_btn  = 1'b0;
        #1;

        // Test 1 and first half of test 4 from the table
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step(tbl[i].alarm, tbl[i].ack);
            chk($sformatf("table[%0d]", i), tbl[i].st, tbl[i].bz, tbl[i].ld, tbl[i].es, tbl[i].ap);
        end

        // Test 4: acknowledge while escalated with alarm gone, then drop to IDLE
        for (int j = 0; j <= 6; j++) begin
            step(1'b0, 1'b1);
            if (j < 6) chk("t4_wait_debounce", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
            else       chk("t4_ack_pulse", 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1);
        chk("t4_snooze_to_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            step(1'b0, 1'b0);
            chk("t4_idle_hold", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Test 2: acknowledge in RINGING, snooze, re-ring
        do_reset();
        step(1'b1, 1'b0); chk("t2_sync0", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0); chk("t2_sync1", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 20; i++) begin
            step(1'b1, 1'b0);
            chk("t2_ring", 2'd1, beep_model(i), 1'b1, 1'b0, 1'b0);
        end
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b1);
            if (j < 6)       chk("t2_press_ring", 2'd1, beep_model(21 + j), 1'b1, 1'b0, 1'b0);
            else if (j == 6) chk("t2_ack_pulse", 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
            else             chk("t2_held_no_repeat", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int s = 4; s < 32; s++) begin
            step(1'b1, 1'b0);
            chk("t2_snooze", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b0);
        chk("t2_rering", 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        rc = 0;

        // Test 3: short button bounces never acknowledge
        for (int i = 0; i < 18; i++) begin
            step(1'b1, glitch[i]);
            rc++;
            chk("t3_glitch", 2'd1, beep_model(rc), 1'b1, 1'b0, 1'b0);
        end

        // Test 5: alarm self-clears during RINGING at cycle 30
        while (rc < 30) begin
            step(1'b1, 1'b0);
            rc++;
            chk("t5_ring", 2'd1, beep_model(rc), 1'b1, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0); chk("t5_sync0", 2'd1, beep_model(31), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0); chk("t5_sync1", 2'd1, beep_model(32), 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0); chk("t5_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0); chk("t5_idle_hold", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Test 6: acknowledge coincides with escalation expiry, then async reset in SNOOZE
        do_reset();
        step(1'b1, 1'b0); chk("t6_sync0", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0); chk("t6_sync1", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i <= 57; i++) begin
            step(1'b1, 1'b0);
            chk("t6_ring", 2'd1, beep_model(i), 1'b1, 1'b0, 1'b0);
        end
        for (int j = 0; j <= 6; j++) begin
            step(1'b1, 1'b1);
            if (j < 6) chk("t6_press_ring", 2'd1, beep_model(58 + j), 1'b1, 1'b0, 1'b0);
            else       chk("t6_ack_beats_escalate", 2'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0);
        chk("t6_snooze", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        alarm_in = 1'b0;
        ack_btn  = 1'b0;
        rst_n    = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step(1'b0, 1'b0);
            chk("t6_after_release", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_response_unit.md
Name: alarm_response_unit

Overview:
- Caregiver-side responder for the smart-room bed/baby alarm. It consumes the alarm level from the bed-alarm block and drives a pulsed buzzer and a status LED.
- It escalates to a continuous buzzer if nobody acknowledges in time, and accepts a debounced acknowledge button that snoozes the alarm.
- It sits between the bed-alarm output and the room annunciator and panel indicators.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive synced-high samples of ack_btn required to register a press (>=1).
- BEEP_ON, 8: buzzer-high cycles per beep period in RINGING (>=1).
- BEEP_OFF, 8: buzzer-low cycles per beep period in RINGING (>=1).
- ESCALATE_CYCLES, 64: cycles in RINGING before escalation (>=2).
- SNOOZE_CYCLES, 32: cycles spent in SNOOZE before re-evaluating alarm_in (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alarm_in  in  1  alarm level from bed-alarm block; asynchronous to clk.
- ack_btn  in  1  raw acknowledge push-button, active high, bouncy.
- buzzer  out  1  annunciator drive.
- led  out  1  high whenever state != IDLE.
- escalate  out  1  high in ESCALATED only.
- ack_pulse  out  1  one-cycle strobe when an acknowledge is accepted.
- state_o  out  2  current state: IDLE=0, RINGING=1, ESCALATED=2, SNOOZE=3.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. All outputs, synchronisers, and counters are 0.
- Input conditioning:
  - alarm_in and ack_btn each pass through a 2-flop synchroniser, giving alarm_s and ack_s.
  - Debounce counter: increments while ack_s=1 and clears to 0 when ack_s=0. It saturates at DEBOUNCE_CYCLES.
  - ack_db sets when the counter reaches DEBOUNCE_CYCLES and clears when ack_s=0.
  - ack_evt is a one-cycle internal pulse on the rising edge of ack_db. A held button yields exactly one ack_evt.
- All outputs are registered and reflect the state after the transition edge.
- IDLE:
  - buzzer=0, led=0.
  - Goes to RINGING when alarm_s=1.
  - ack_evt is ignored.
- RINGING:
  - On entry, the beep counter and escalation counter clear, and buzzer=1 in the first RINGING cycle.
  - Buzzer is 1 for BEEP_ON cycles, then 0 for BEEP_OFF cycles, repeating.
  - Priority, highest first:
    1. ack_evt: go to SNOOZE, ack_pulse=1 for that cycle.
    2. Escalation counter == ESCALATE_CYCLES-1: go to ESCALATED.
    3. alarm_s=0: go to IDLE (self-cleared).
- ESCALATED:
  - buzzer=1 continuously, escalate=1.
  - The state is latched: alarm_s falling does NOT leave it.
  - ack_evt: go to SNOOZE with ack_pulse=1.
- SNOOZE:
  - buzzer=0, led=1.
  - The snooze counter clears on entry.
  - alarm_s=0 at any cycle: go to IDLE immediately.
  - At counter == SNOOZE_CYCLES-1 with alarm_s=1: go to RINGING with fresh counters.
  - ack_evt is ignored.
- Latency:
  - alarm_in rising before edge k: state_o=1 and buzzer=1 after edge k+2.
  - ack_btn rising before edge k (stable): ack_pulse after edge k+2+DEBOUNCE_CYCLES.
- Glitch rejection: ack_btn pulses shorter than DEBOUNCE_CYCLES synced samples never produce ack_evt.
- Reset mid-operation: immediate return to reset values regardless of state. No ack_pulse is generated by reset release.
- Counter widths: each counter is sized by $clog2 of its parameter plus 1. No wrap occurs inside a state because counters clear on state entry.

Test Plan:
1. Reset, then alarm_in=1 held, defaults. Required: state_o=1 two cycles after sampling. Buzzer pattern is 8 high / 8 low. At RINGING cycle 64, state_o=2, escalate=1, buzzer=1 constant.
2. In RINGING at cycle 20, ack_btn held high for 10 cycles. Required: exactly one ack_pulse 6 cycles after the press and state_o=3. After 32 cycles, with alarm_in still 1, state_o=1 and buzzer=1.
3. ack_btn bounce of 1-, 2-, and 3-cycle pulses in RINGING. Required: no ack_pulse, and state stays 1.
4. ESCALATED, then alarm_in drops to 0. Required: state_o stays 2. A subsequent valid press gives ack_pulse and state_o=3. The next cycle goes to state_o=0 because alarm_s=0.
5. RINGING, alarm_in drops at cycle 30 with no ack. Required: state_o=0, buzzer=0, led=0, and no ack_pulse.
6. ack_evt timed to coincide with escalation-counter expiry. Required: ack wins, with state_o=3 and ack_pulse=1. Also assert rst_n=0 mid-SNOOZE: all outputs go to 0 asynchronously.
